// File: rtl/ring_port.sv
// Slide-unit endpoint of the inter-cluster ring: configures the router, streams TX beats, buffers RX beats.
// Optional feature macro: RING_PORT_TX_SKID_EN (registered 2-entry spill on the TX path).
module ring_port #(
   parameter int NrClusters  = 2,
   parameter int DataWidth   = 64,
   parameter int RxFifoDepth = 4,
   parameter int CntWidth    = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 op_valid_i,
   output logic                 op_ready_o,
   input  logic                 op_dir_i,
   input  logic [CntWidth-1:0]  op_ntx_i,
   input  logic [CntWidth-1:0]  op_nrx_i,
   output logic                 done_o,
   input  logic [DataWidth-1:0] tx_data_i,
   input  logic                 tx_valid_i,
   output logic                 tx_ready_o,
   output logic [DataWidth-1:0] rx_data_o,
   output logic                 rx_valid_o,
   input  logic                 rx_ready_i,
   output logic [DataWidth-1:0] ring_data_o,
   output logic                 ring_valid_o,
   input  logic                 ring_ready_i,
   input  logic [DataWidth-1:0] ring_data_i,
   input  logic                 ring_valid_i,
   output logic                 ring_ready_o,
   output logic                 sldu_dir_o,
   output logic                 sldu_bypass_o,
   output logic                 sldu_config_valid_o
);

   localparam int PtrW = (RxFifoDepth > 1) ? $clog2(RxFifoDepth) : 1;

   if (NrClusters < 2) begin : g_bad_nr_clusters
      $error("ring_port: NrClusters must be >= 2");
   end
   if ((RxFifoDepth < 2) || ((RxFifoDepth & (RxFifoDepth - 1)) != 0)) begin : g_bad_depth
      $error("ring_port: RxFifoDepth must be a power of two >= 2");
   end

   typedef enum logic [1:0] {IDLE, CONFIG, XFER, DONE} state_e;

   state_e                state_q, state_d;
   logic                  alive_q;
   logic [CntWidth-1:0]   tx_rem_q, tx_rem_d;
   logic [CntWidth-1:0]   rx_rem_q, rx_rem_d;
   logic                  dir_q, dir_d;
   logic                  bypass_q, bypass_d;

   logic [DataWidth-1:0]  fifo_q [RxFifoDepth];
   logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [PtrW:0]         fill_q;
   logic                  fifo_full, fifo_empty;
   logic                  push, pop;
   logic                  in_xfer, tx_hs, tx_idle;

   assign in_xfer = (state_q == XFER);

   // Valid/ready: a beat moves on a cycle where both are high at the clock edge;
   // a valid source keeps its data stable until that handshake.
`ifdef RING_PORT_TX_SKID_EN
   logic                 a_valid_q, b_valid_q;
   logic [DataWidth-1:0] a_data_q, b_data_q;
   logic                 out_hs;

   assign tx_ready_o   = in_xfer && (tx_rem_q != '0) && !b_valid_q;
   assign tx_hs        = tx_valid_i && tx_ready_o;
   assign ring_valid_o = a_valid_q;
   assign ring_data_o  = a_data_q;
   assign out_hs       = a_valid_q && ring_ready_i;
   assign tx_idle      = !a_valid_q && !b_valid_q;

   // Slot a drives the ring; slot b only fills while a is stalled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         a_valid_q <= 1'b0;
         b_valid_q <= 1'b0;
         a_data_q  <= '0;
         b_data_q  <= '0;
      end else if (out_hs) begin
         if (b_valid_q) begin
            a_data_q  <= b_data_q;
            b_valid_q <= tx_hs;
            if (tx_hs) b_data_q <= tx_data_i;
         end else begin
            a_valid_q <= tx_hs;
            if (tx_hs) a_data_q <= tx_data_i;
         end
      end else if (tx_hs) begin
         if (a_valid_q) begin
            b_valid_q <= 1'b1;
            b_data_q  <= tx_data_i;
         end else begin
            a_valid_q <= 1'b1;
            a_data_q  <= tx_data_i;
         end
      end
   end
`else
   assign tx_ready_o   = in_xfer && (tx_rem_q != '0) && ring_ready_i;
   assign ring_valid_o = in_xfer && tx_valid_i && (tx_rem_q != '0);
   assign ring_data_o  = ring_valid_o ? tx_data_i : '0;
   assign tx_hs        = tx_valid_i && tx_ready_o;
   assign tx_idle      = 1'b1;
`endif

   assign fifo_empty   = (fill_q == '0);
   assign fifo_full    = (fill_q == (PtrW+1)'(RxFifoDepth));
   // No pass-through when full: a same-cycle pop does not free a slot for the incoming beat.
   assign ring_ready_o = in_xfer && (rx_rem_q != '0) && !fifo_full;
   assign push         = ring_valid_i && ring_ready_o;
   assign rx_valid_o   = !fifo_empty;
   assign pop          = rx_valid_o && rx_ready_i;
   assign rx_data_o    = fifo_empty ? '0 : fifo_q[rd_ptr_q];

   assign op_ready_o          = alive_q && (state_q == IDLE);
   assign sldu_config_valid_o = (state_q == CONFIG);
   assign done_o              = (state_q == DONE);
   assign sldu_dir_o          = dir_q;
   assign sldu_bypass_o       = bypass_q;

   always_comb begin
      state_d  = state_q;
      tx_rem_d = tx_rem_q;
      rx_rem_d = rx_rem_q;
      dir_d    = dir_q;
      bypass_d = bypass_q;
      case (state_q)
         IDLE: begin
            if (op_valid_i && op_ready_o) begin
               dir_d    = op_dir_i;
               bypass_d = (op_ntx_i == '0) && (op_nrx_i == '0);
               tx_rem_d = op_ntx_i;
               rx_rem_d = op_nrx_i;
               state_d  = CONFIG;
            end
         end
         CONFIG: state_d = bypass_q ? DONE : XFER;
         XFER: begin
            if (tx_hs) tx_rem_d = tx_rem_q - CntWidth'(1);
            if (push)  rx_rem_d = rx_rem_q - CntWidth'(1);
            if ((tx_rem_q == '0) && (rx_rem_q == '0) && fifo_empty && tx_idle) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= IDLE;
         alive_q  <= 1'b0;
         tx_rem_q <= '0;
         rx_rem_q <= '0;
         dir_q    <= 1'b0;
         bypass_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         alive_q  <= 1'b1;
         tx_rem_q <= tx_rem_d;
         rx_rem_q <= rx_rem_d;
         dir_q    <= dir_d;
         bypass_q <= bypass_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
         case ({push, pop})
            2'b10:   fill_q <= fill_q + (PtrW+1)'(1);
            2'b01:   fill_q <= fill_q - (PtrW+1)'(1);
            default: fill_q <= fill_q;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (push) fifo_q[wr_ptr_q] <= ring_data_i;
   end

endmodule

// File: tb/tb_ring_port.sv
// Self-checking bench for ring_port: descriptor table plus hand sequences for stall, full FIFO and reset.
module tb_ring_port;
   localparam int DW    = 64;
   localparam int CW    = 16;
   localparam int DEPTH = 4;

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          op_valid_i, op_ready_o, op_dir_i;
   logic [CW-1:0] op_ntx_i, op_nrx_i;
   logic          done_o;
   logic [DW-1:0] tx_data_i;
   logic          tx_valid_i, tx_ready_o;
   logic [DW-1:0] rx_data_o;
   logic          rx_valid_o, rx_ready_i;
   logic [DW-1:0] ring_data_o;
   logic          ring_valid_o, ring_ready_i;
   logic [DW-1:0] ring_data_i;
   logic          ring_valid_i, ring_ready_o;
   logic          sldu_dir_o, sldu_bypass_o, sldu_config_valid_o;

   ring_port #(.NrClusters(2), .DataWidth(DW), .RxFifoDepth(DEPTH), .CntWidth(CW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_dir_i(op_dir_i),
      .op_ntx_i(op_ntx_i), .op_nrx_i(op_nrx_i), .done_o(done_o),
      .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
      .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
      .ring_data_o(ring_data_o), .ring_valid_o(ring_valid_o), .ring_ready_i(ring_ready_i),
      .ring_data_i(ring_data_i), .ring_valid_i(ring_valid_i), .ring_ready_o(ring_ready_o),
      .sldu_dir_o(sldu_dir_o), .sldu_bypass_o(sldu_bypass_o),
      .sldu_config_valid_o(sldu_config_valid_o)
   );

   always #5 clk_i = ~clk_i;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   always @(posedge clk_i) cyc++;

   logic [DW-1:0] tx_src_q[$], ring_src_q[$], exp_ring_q[$], exp_rx_q[$];
   int  tx_hs_cnt, ring_out_cnt, rx_in_cnt, rx_out_cnt, done_cnt, occ;
   int  first_ring_cyc, last_ring_cyc, first_pop_cyc, last_pop_cyc;
   logic rr_level, rx_rdy_level, rr_toggle;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Drivers: present source-queue heads and ready levels half a cycle before the edge.
   always @(negedge clk_i) begin
      #1;
      tx_valid_i   = (tx_src_q.size() > 0);
      tx_data_i    = (tx_src_q.size() > 0) ? tx_src_q[0] : '0;
      ring_valid_i = (ring_src_q.size() > 0);
      ring_data_i  = (ring_src_q.size() > 0) ? ring_src_q[0] : '0;
      ring_ready_i = rr_toggle ? ~cyc[0] : rr_level;
      rx_ready_i   = rx_rdy_level;
   end

   // Monitor: handshakes seen here commit on the next rising edge.
   logic          th, prev_th, prev_rv, prev_rr;
   logic [DW-1:0] prev_rd, prev_td, e;
   int            occ_now;
   always @(negedge clk_i) begin
      #3;
      if (!rst_ni) begin
         prev_th = 1'b0; prev_rv = 1'b0; prev_rr = 1'b0; occ = 0;
      end else begin
         occ_now = occ;
         th = tx_valid_i && tx_ready_o;
         check("rx_valid_model", rx_valid_o, occ_now != 0);
`ifdef RING_PORT_TX_SKID_EN
         if (prev_th && !prev_rv) begin
            check("skid_lat_valid", ring_valid_o, 1'b1);
            check("skid_lat_data", ring_data_o, prev_td);
         end
`else
         if (th) begin
            check("tx_passthru_valid", ring_valid_o, 1'b1);
            check("tx_passthru_data", ring_data_o, tx_data_i);
         end
`endif
         if (prev_rv && !prev_rr) begin
            check("ring_hold_valid", ring_valid_o, 1'b1);
            check("ring_hold_data", ring_data_o, prev_rd);
         end
         if (th) begin
            tx_hs_cnt++;
            void'(tx_src_q.pop_front());
         end
         if (ring_valid_o && ring_ready_i) begin
            ring_out_cnt++;
            if (first_ring_cyc < 0) first_ring_cyc = cyc;
            last_ring_cyc = cyc;
            if (exp_ring_q.size() == 0) check("ring_extra_beat", ring_data_o, 64'hDEAD);
            else begin
               e = exp_ring_q.pop_front();
               check("ring_data", ring_data_o, e);
            end
         end
         if (occ_now == DEPTH) check("full_holds_ring", ring_ready_o, 1'b0);
         if (ring_valid_i && ring_ready_o) begin
            rx_in_cnt++;
            occ++;
            void'(ring_src_q.pop_front());
         end
         if (rx_valid_o && rx_ready_i) begin
            rx_out_cnt++;
            occ--;
            if (first_pop_cyc < 0) first_pop_cyc = cyc;
            last_pop_cyc = cyc;
            if (exp_rx_q.size() == 0) check("rx_extra_word", rx_data_o, 64'hDEAD);
            else begin
               e = exp_rx_q.pop_front();
               check("rx_data", rx_data_o, e);
            end
         end
         if (done_o) done_cnt++;
         prev_th = th; prev_td = tx_data_i;
         prev_rv = ring_valid_o; prev_rr = ring_ready_i; prev_rd = ring_data_o;
      end
   end

   task automatic start_op(input logic dir, input int ntx, input int nrx,
                           input int tx_offer, input int rx_offer);
      logic [DW-1:0] w;
      @(posedge clk_i); #1;
      tx_hs_cnt = 0; ring_out_cnt = 0; rx_in_cnt = 0; rx_out_cnt = 0; done_cnt = 0;
      first_ring_cyc = -1; first_pop_cyc = -1; last_ring_cyc = 0; last_pop_cyc = 0;
      for (int i = 0; i < tx_offer; i++) begin
         w = {$urandom, $urandom};
         tx_src_q.push_back(w);
         if (i < ntx) exp_ring_q.push_back(w);
      end
      for (int i = 0; i < rx_offer; i++) begin
         w = {$urandom, $urandom};
         ring_src_q.push_back(w);
         if (i < nrx) exp_rx_q.push_back(w);
      end
      op_valid_i = 1'b1; op_dir_i = dir; op_ntx_i = CW'(ntx); op_nrx_i = CW'(nrx);
      check("op_ready_idle", op_ready_o, 1'b1);
      @(posedge clk_i); #1;
      op_valid_i = 1'b0;
      check("config_strobe", sldu_config_valid_o, 1'b1);
      check("sldu_dir", sldu_dir_o, dir);
      check("sldu_bypass", sldu_bypass_o, (ntx == 0) && (nrx == 0));
   endtask

   task automatic wait_done(input int budget, output int waited);
      logic got = 1'b0;
      waited = 0;
      while (!got && waited < budget) begin
         @(posedge clk_i); #1;
         waited++;
         if (done_o) got = 1'b1;
      end
      check("done_seen", got, 1'b1);
      @(posedge clk_i); #1;
      check("done_one_cycle", done_o, 1'b0);
      check("done_count", done_cnt, 1);
      check("back_idle", op_ready_o, 1'b1);
   endtask

   typedef struct {
      logic dir; int ntx; int nrx; int tx_offer; int rx_offer; logic full_rate;
   } vec_t;
   vec_t vecs[6];

   initial begin
      int waited, n;
      rst_ni = 1'b0; op_valid_i = 1'b0; op_dir_i = 1'b0; op_ntx_i = '0; op_nrx_i = '0;
      tx_valid_i = 1'b0; tx_data_i = '0; ring_valid_i = 1'b0; ring_data_i = '0;
      ring_ready_i = 1'b0; rx_ready_i = 1'b0;
      rr_level = 1'b1; rx_rdy_level = 1'b1; rr_toggle = 1'b0; occ = 0;

      vecs[0] = '{1'b1, 0, 0, 2, 2, 1'b0};
      vecs[1] = '{1'b0, 8, 8, 8, 8, 1'b1};
      vecs[2] = '{1'b1, 3, 2, 5, 4, 1'b0};
      vecs[3] = '{1'b0, 1, 0, 1, 0, 1'b0};
      vecs[4] = '{1'b1, 0, 3, 0, 3, 1'b0};
      n = $urandom_range(1, 6);
      vecs[5] = '{1'b0, n, 7 - n, n + 1, 8 - n, 1'b0};

      #2;
      check("reset_outputs", {op_ready_o, done_o, tx_ready_o, rx_valid_o, ring_valid_o,
                              ring_ready_o, sldu_dir_o, sldu_bypass_o, sldu_config_valid_o,
                              (rx_data_o != '0), (ring_data_o != '0)}, '0);
      @(posedge clk_i); #1;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      check("op_ready_after_reset", op_ready_o, 1'b1);

      for (int v = 0; v < 6; v++) begin
         start_op(vecs[v].dir, vecs[v].ntx, vecs[v].nrx, vecs[v].tx_offer, vecs[v].rx_offer);
         wait_done(100, waited);
         if (vecs[v].ntx == 0 && vecs[v].nrx == 0) check("bypass_done_t2", waited, 1);
         check("tx_accepted", tx_hs_cnt, vecs[v].ntx);
         check("ring_out_count", ring_out_cnt, vecs[v].ntx);
         check("rx_accepted", rx_in_cnt, vecs[v].nrx);
         check("rx_delivered", rx_out_cnt, vecs[v].nrx);
         check("tx_ready_after", tx_ready_o, 1'b0);
         if (vecs[v].full_rate) begin
            check("tx_back_to_back", last_ring_cyc - first_ring_cyc, vecs[v].ntx - 1);
            check("rx_back_to_back", last_pop_cyc - first_pop_cyc, vecs[v].nrx - 1);
         end
         tx_src_q.delete(); ring_src_q.delete();
         exp_ring_q.delete(); exp_rx_q.delete();
      end

      // RX FIFO fills and backpressures the ring, then drains across the pointer wrap.
      rx_rdy_level = 1'b0;
      start_op(1'b0, 0, 6, 0, 6);
      repeat (10) @(posedge clk_i);
      #1;
      check("full_accepted", rx_in_cnt, DEPTH);
      check("full_ring_ready", ring_ready_o, 1'b0);
      check("full_rx_valid", rx_valid_o, 1'b1);
      check("full_head", rx_data_o, exp_rx_q[0]);
      rx_rdy_level = 1'b1;
      wait_done(100, waited);
      check("full_total_rx", rx_out_cnt, 6);

      // Ring stalls every other cycle; held beats are checked by the monitor.
      rr_toggle = 1'b1;
      start_op(1'b1, 4, 0, 4, 0);
      wait_done(100, waited);
      check("toggle_tx_count", ring_out_cnt, 4);
      rr_toggle = 1'b0;

      // Reset in the middle of a transfer.
      start_op(1'b0, 5, 5, 5, 5);
      waited = 0;
      while (!(tx_hs_cnt >= 2 && rx_in_cnt >= 2) && waited < 20) begin
         @(posedge clk_i); #1;
         waited++;
      end
      check("midxfer_reached", (tx_hs_cnt >= 2) && (rx_in_cnt >= 2), 1'b1);
      rst_ni = 1'b0;
      tx_src_q.delete(); ring_src_q.delete(); exp_ring_q.delete(); exp_rx_q.delete();
      #1;
      check("midreset_outputs", {op_ready_o, done_o, tx_ready_o, rx_valid_o, ring_valid_o,
                                 ring_ready_o, sldu_dir_o, sldu_bypass_o, sldu_config_valid_o,
                                 (rx_data_o != '0), (ring_data_o != '0)}, '0);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(posedge clk_i); #1;
      check("post_reset_ready", op_ready_o, 1'b1);
      check("post_reset_fifo_empty", rx_valid_o, 1'b0);

      start_op(1'b1, 2, 2, 2, 2);
      wait_done(100, waited);
      check("recover_tx", ring_out_cnt, 2);
      check("recover_rx", rx_out_cnt, 2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/ring_port.md
# ring_port

Slide-unit-side endpoint of the inter-cluster ring, placed inside each Ara instance between the slide unit and its cluster's ring router. It accepts one ring operation descriptor per slide, issues the matching one-cycle configuration (direction, bypass) to the router, then streams outgoing element words onto the ring and buffers incoming ones for the slide unit. It completes once the programmed beat counts have been exchanged.

## Interface
Parameters:
- NrClusters, 2: number of Ara instances on the ring; must be >= 2.
- DataWidth, 64: ring word width (elen).
- RxFifoDepth, 4: RX buffer entries; power of two, >= 2.
- CntWidth, 16: width of the beat counters.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- op_valid_i  in  1  operation descriptor valid.
- op_ready_o  out  1  descriptor accepted (high only in IDLE).
- op_dir_i  in  1  0 = slidedown (left), 1 = slideup (right).
- op_ntx_i  in  CntWidth  beats to transmit.
- op_nrx_i  in  CntWidth  beats to receive.
- done_o  out  1  one-cycle pulse when the operation completes.
- tx_data_i  in  DataWidth  outgoing word from the slide unit.
- tx_valid_i / tx_ready_o  in / out  1  TX handshake.
- rx_data_o  out  DataWidth  incoming word to the slide unit.
- rx_valid_o / rx_ready_i  out / in  1  RX handshake.
- ring_data_o, ring_valid_o / ring_ready_i  out, out / in  DataWidth, 1, 1  to the router.
- ring_data_i, ring_valid_i / ring_ready_o  in, in / out  DataWidth, 1, 1  from the router.
- sldu_dir_o  out  1  registered direction.
- sldu_bypass_o  out  1  registered bypass.
- sldu_config_valid_o  out  1  configuration strobe.

## Operation
- FSM states: IDLE, CONFIG, XFER, DONE.
- IDLE: op_ready_o = 1. On op_valid_i:
  - latch dir;
  - set bypass = (op_ntx_i == 0 && op_nrx_i == 0);
  - load tx_rem = op_ntx_i, rx_rem = op_nrx_i;
  - go to CONFIG.
- CONFIG: sldu_config_valid_o = 1 for exactly this cycle. Go to DONE if bypass, else XFER.
- XFER, TX path:
  - tx_ready_o = (tx_rem != 0) && ring_ready_i;
  - ring_valid_o = tx_valid_i && tx_rem != 0;
  - each TX handshake decrements tx_rem.
- XFER, RX path:
  - ring_ready_o = (rx_rem != 0) && !fifo_full;
  - each accepted beat is pushed into the FIFO and decrements rx_rem.
  - The FIFO pops on rx_valid_o && rx_ready_i; rx_valid_o = !fifo_empty.
- XFER exits to DONE when tx_rem == 0, rx_rem == 0 and the FIFO is empty.
- DONE: done_o = 1 for one cycle, then IDLE.
- Counters are unsigned CntWidth values and never decrement below 0. Surplus ring beats are held off via ring_ready_o = 0; surplus TX words are held off via tx_ready_o = 0.
- sldu_dir_o and sldu_bypass_o hold their values from acceptance until the next descriptor.

## Timing
- Reset values: all outputs 0. op_ready_o becomes 1 in the first cycle after reset release (state IDLE). FIFO is empty, counters are 0.
- Descriptor accepted in cycle t: sldu_config_valid_o is high in t+1. The first TX/RX handshake can occur in t+2.
- Minimum operation duration with bypass: done_o in t+2.
- Full throughput: one TX beat and one RX beat per cycle, sustained.
- RX latency: a ring beat accepted in cycle c is visible on rx_data_o in c+1.
- FIFO full: ring_ready_o = 0 even if a pop occurs in the same cycle; there is no same-cycle pass-through.
- FIFO wrap-around: pointers wrap modulo RxFifoDepth. Order is preserved.
- ring_valid_o never drops without a handshake while tx_valid_i holds, as required by the router protocol.
- Reset asserted mid-operation: immediate return to IDLE; FIFO is flushed, counters are cleared, all outputs return to 0.

## Configuration
- RING_PORT_TX_SKID_EN defined:
  - the TX path passes through a 2-entry spill register;
  - ring_data_o and ring_valid_o are register outputs;
  - tx_ready_o depends only on spill occupancy and tx_rem, with no combinational path from ring_ready_i;
  - TX latency is 1 cycle, full throughput is kept;
  - tx_rem decrements on the input-side handshake;
  - the XFER exit condition additionally requires the spill register to be empty.
- RING_PORT_TX_SKID_EN undefined: the combinational TX pass-through described above, with 0-cycle latency.

## Test plan
- Reset mid-XFER with ntx=5, nrx=5 after 2 beats each -> all outputs 0, op_ready_o = 1 after release, the FIFO reads empty.
- Descriptor dir=1, ntx=0, nrx=0 -> sldu_bypass_o = 1, sldu_dir_o = 1, config strobe in t+1, done_o in t+2, no ring handshakes.
- ntx=8, nrx=8, with ring_ready_i, ring_valid_i and rx_ready_i held high -> 8 words leave in order in 8 consecutive cycles, 8 words arrive in order, done_o asserts once.
- nrx=6, rx_ready_i = 0, RxFifoDepth=4 -> ring_ready_o drops after 4 beats. Raise rx_ready_i -> all 6 delivered in order, including across the pointer wrap.
- ntx=3 with 5 words offered -> exactly 3 accepted, tx_ready_o = 0 afterwards. Ring offers 4 beats with nrx=2 -> only 2 accepted.
- ring_ready_i toggled 1,0,1,0 with ntx=4 -> ring_valid_o and ring_data_o stay stable while stalled. With RING_PORT_TX_SKID_EN defined, each word appears one cycle after its TX handshake.
